// File: rtl/wavetable_record_ctrl_pkg.sv
// wavetable_record_ctrl_pkg: shared constants and FSM encoding for the wavetable recorder
package wavetable_record_ctrl_pkg;
  localparam int TABLE_LEN = 32;
  localparam int IDX_W = $clog2(TABLE_LEN);
  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_COMMIT, ST_DONE} state_t;
endpackage

// File: rtl/wavetable_record_ctrl_if.sv
// wavetable_record_ctrl_if: record button, mic and playback handshake bundle
interface wavetable_record_ctrl_if;
  import wavetable_record_ctrl_pkg::*;
  logic                 record;
  logic                 mic_in;
  logic                 table_ack;
  logic                 busy;
  logic                 sample_stb;
  logic [IDX_W-1:0]     bit_idx;
  logic [0:TABLE_LEN-1] wavetable_out;
  logic                 table_valid;
  logic                 aborted;
  modport master (
    output record, mic_in, table_ack,
    input  busy, sample_stb, bit_idx, wavetable_out, table_valid, aborted
  );
  modport slave (
    input  record, mic_in, table_ack,
    output busy, sample_stb, bit_idx, wavetable_out, table_valid, aborted
  );
endinterface

// File: rtl/wavetable_record_ctrl_sample_tick_gen.sv
// sample_tick_gen: free-running divider that pulses once every CLK_DIV enabled cycles
module sample_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  logic [15:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= (!i_en || r_cnt == LAST) ? '0 : r_cnt + 16'd1;
  end
  assign o_tick = i_en && r_cnt == LAST;
endmodule

// File: rtl/wavetable_record_ctrl.sv
// wavetable_record_ctrl: records 32 mic samples into a shadow table and hands it to playback
module wavetable_record_ctrl
  import wavetable_record_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  wavetable_record_ctrl_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_LEN - 1);
  state_t               r_state, w_next;
  logic                 r_sync1, r_sync2, r_rec_d;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [0:TABLE_LEN-1] r_shadow, r_table;
  logic                 r_valid, r_aborted;
  logic                 w_rec_s, w_rise, w_stb, w_commit, w_tick_en;
  assign w_rec_s   = r_sync2;
  assign w_rise    = w_rec_s && !r_rec_d;
  // divider only runs while a capture is live, so an abort cycle cannot strobe
  assign w_tick_en = r_state == ST_CAPTURE && w_rec_s;
  assign w_commit  = r_state == ST_COMMIT && (!r_valid || bus.table_ack);
  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (w_tick_en),
    .o_tick (w_stb)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = w_rise ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: w_next = !w_rec_s ? ST_IDLE : (w_stb && r_bit_idx == LAST_IDX) ? ST_COMMIT : ST_CAPTURE;
      ST_COMMIT:  w_next = w_commit ? ST_DONE : ST_COMMIT;
      ST_DONE:    w_next = w_rec_s ? ST_DONE : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_rec_d   <= 1'b0;
      r_bit_idx <= '0;
      r_shadow  <= '0;
      r_table   <= '0;
      r_valid   <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_sync1   <= bus.record;
      r_sync2   <= r_sync1;
      r_rec_d   <= r_sync2;
      r_aborted <= r_state == ST_CAPTURE && !w_rec_s;
      if (r_state == ST_IDLE && w_rise) begin
        r_bit_idx <= '0;
        r_shadow  <= '0;
      end else if (w_stb) begin
        r_shadow[r_bit_idx] <= bus.mic_in;
        r_bit_idx           <= r_bit_idx + 1'b1;
      end
      if (w_commit) begin
        r_table <= r_shadow;
        r_valid <= 1'b1;
      end else if (bus.table_ack) r_valid <= 1'b0;
    end
  end
  assign bus.busy          = r_state == ST_CAPTURE || r_state == ST_COMMIT;
  assign bus.sample_stb    = w_stb;
  assign bus.bit_idx       = r_bit_idx;
  assign bus.wavetable_out = r_table;
  assign bus.table_valid   = r_valid;
  assign bus.aborted       = r_aborted;
endmodule

// File: tb/tb_wavetable_record_ctrl.sv
// tb_wavetable_record_ctrl: randomized scenario bench with a sample-queue reference model
module tb_wavetable_record_ctrl;
  localparam int DIV = 4;
  localparam int BUDGET = 32 * DIV + 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wavetable_record_ctrl_if bus();
  wavetable_record_ctrl #(.CLK_DIV(DIV)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_checks = 0;
  int n_fail = 0;
  int n_abort = 0;
  int n_stray = 0;
  int entry_cyc = 0;
  logic prev_busy = 1'b0;
  logic [31:0] pat = '0;
  logic samp[$];
  int stb_cyc[$];
  logic [0:31] exp_tbl = '0;
  logic exp_valid = 1'b0;

  // one negedge: present the next pattern bit, then log whatever the DUT shows
  task automatic step();
    int idx;
    @(negedge clk);
    idx = 31 - samp.size();
    bus.mic_in = (idx >= 0) ? pat[idx] : 1'($urandom);
    if (bus.sample_stb) begin
      samp.push_back(bus.mic_in);
      stb_cyc.push_back(cyc);
      if (!bus.busy) n_stray++;
    end
    if (bus.aborted) n_abort++;
    if (bus.busy && !prev_busy) entry_cyc = cyc;
    prev_busy = bus.busy;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic capture(input logic [31:0] p);
    int b = 0;
    int idx_bad = 0;
    int gap_bad = 0;
    logic [0:31] got;
    pat = p;
    samp.delete();
    stb_cyc.delete();
    bus.record = 1'b1;
    while (samp.size() < 32 && b < BUDGET) begin
      step();
      b++;
      if (bus.busy && (6'(bus.bit_idx) + 6'(bus.sample_stb)) != 6'(samp.size())) idx_bad++;
    end
    n_checks++;
    if (samp.size() != 32) begin
      n_fail++;
      $display("FAIL capture_strobes: got %0d strobes, need 32", samp.size());
      return;
    end
    for (int i = 1; i < 32; i++) if (stb_cyc[i] - stb_cyc[i-1] != DIV) gap_bad++;
    for (int i = 0; i < 32; i++) got[i] = samp[i];
    n_checks++;
    if (gap_bad != 0) begin n_fail++; $display("FAIL strobe_spacing: %0d gaps not %0d cycles", gap_bad, DIV); end
    n_checks++;
    if (stb_cyc[0] - entry_cyc != DIV - 1) begin
      n_fail++; $display("FAIL first_strobe_latency: got %0d, need %0d", stb_cyc[0] - entry_cyc, DIV - 1);
    end
    n_checks++;
    if (stb_cyc[31] - entry_cyc != 32 * DIV - 1) begin
      n_fail++; $display("FAIL last_strobe_latency: got %0d, need %0d", stb_cyc[31] - entry_cyc, 32 * DIV - 1);
    end
    n_checks++;
    if (idx_bad != 0) begin n_fail++; $display("FAIL bit_idx_track: %0d cycles off", idx_bad); end
    n_checks++;
    if (got !== p) begin n_fail++; $display("FAIL sampled_bits: got %h, need %h", got, p); end
  endtask

  task automatic test_reset();
    bus.record = 1'b0;
    bus.mic_in = 1'b0;
    bus.table_ack = 1'b0;
    rst_n = 1'b0;
    steps(3);
    n_checks++;
    if ({bus.busy, bus.sample_stb, bus.table_valid, bus.aborted} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, need 0000", {bus.busy, bus.sample_stb, bus.table_valid, bus.aborted});
    end
    n_checks++;
    if (bus.bit_idx !== 5'd0) begin n_fail++; $display("FAIL reset_bit_idx: got %0d, need 0", bus.bit_idx); end
    n_checks++;
    if (bus.wavetable_out !== 32'h0) begin n_fail++; $display("FAIL reset_table: got %h, need 0", bus.wavetable_out); end
    rst_n = 1'b1;
    steps(3);
  endtask

  task automatic test_basic_capture();
    capture(32'hA5A5_0F0F);
    steps(3);
    exp_tbl = 32'hA5A5_0F0F;
    exp_valid = 1'b1;
    n_checks++;
    if (bus.wavetable_out !== exp_tbl) begin n_fail++; $display("FAIL basic_table: got %h, need %h", bus.wavetable_out, exp_tbl); end
    n_checks++;
    if (bus.table_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_flags: valid=%b busy=%b, need valid=1 busy=0", bus.table_valid, bus.busy);
    end
  endtask

  task automatic test_hold_no_retrigger();
    steps(10 * DIV);
    n_checks++;
    if (samp.size() != 32 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_retrigger: strobes=%0d busy=%b, need 32 and 0", samp.size(), bus.busy);
    end
    bus.record = 1'b0;
    steps(4);
  endtask

  task automatic test_abort();
    int ab0 = n_abort;
    int b = 0;
    pat = $urandom;
    samp.delete();
    stb_cyc.delete();
    bus.record = 1'b1;
    while (samp.size() < 10 && b < BUDGET) begin step(); b++; end
    bus.record = 1'b0;
    steps(6);
    n_checks++;
    if (n_abort - ab0 != 1) begin n_fail++; $display("FAIL abort_pulses: got %0d, need 1", n_abort - ab0); end
    n_checks++;
    if (bus.busy !== 1'b0 || samp.size() < 10 || samp.size() > 12) begin
      n_fail++; $display("FAIL abort_idle: busy=%b strobes=%0d, need busy=0 and 10..12", bus.busy, samp.size());
    end
    n_checks++;
    if (bus.wavetable_out !== exp_tbl || bus.table_valid !== exp_valid) begin
      n_fail++; $display("FAIL abort_keeps_table: got %h/%b, need %h/%b", bus.wavetable_out, bus.table_valid, exp_tbl, exp_valid);
    end
  endtask

  task automatic test_commit_hold();
    logic [31:0] p = $urandom;
    capture(p);
    steps(2 * DIV);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.table_valid !== 1'b1 || bus.wavetable_out !== exp_tbl) begin
      n_fail++; $display("FAIL commit_hold: busy=%b valid=%b table=%h, need 1/1/%h", bus.busy, bus.table_valid, bus.wavetable_out, exp_tbl);
    end
    bus.table_ack = 1'b1;
    step();
    bus.table_ack = 1'b0;
    exp_tbl = p;
    n_checks++;
    if (bus.wavetable_out !== exp_tbl || bus.table_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL commit_on_ack: table=%h valid=%b busy=%b, need %h/1/0", bus.wavetable_out, bus.table_valid, bus.busy, exp_tbl);
    end
    bus.record = 1'b0;
    steps(4);
  endtask

  task automatic test_ack_clear();
    bus.table_ack = 1'b1;
    step();
    bus.table_ack = 1'b0;
    exp_valid = 1'b0;
    n_checks++;
    if (bus.table_valid !== exp_valid || bus.wavetable_out !== exp_tbl) begin
      n_fail++; $display("FAIL ack_clear: valid=%b table=%h, need 0/%h", bus.table_valid, bus.wavetable_out, exp_tbl);
    end
    bus.table_ack = 1'b1;
    step();
    bus.table_ack = 1'b0;
    steps(2);
    n_checks++;
    if (bus.table_valid !== 1'b0 || bus.busy !== 1'b0 || bus.wavetable_out !== exp_tbl) begin
      n_fail++; $display("FAIL ack_when_empty: valid=%b busy=%b table=%h", bus.table_valid, bus.busy, bus.wavetable_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] p = $urandom;
      capture(p);
      steps(3);
      exp_tbl = p;
      n_checks++;
      if (bus.wavetable_out !== exp_tbl || bus.table_valid !== 1'b1) begin
        n_fail++; $display("FAIL back_to_back_%0d: table=%h valid=%b, need %h/1", k, bus.wavetable_out, bus.table_valid, exp_tbl);
      end
      bus.record = 1'b0;
      steps(3);
      bus.table_ack = 1'b1;
      step();
      bus.table_ack = 1'b0;
    end
    exp_valid = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    int ab0;
    int b = 0;
    pat = $urandom;
    samp.delete();
    stb_cyc.delete();
    bus.record = 1'b1;
    while (bus.bit_idx != 5'd17 && b < BUDGET) begin step(); b++; end
    n_checks++;
    if (bus.bit_idx !== 5'd17) begin n_fail++; $display("FAIL reach_idx17: got %0d, need 17", bus.bit_idx); end
    rst_n = 1'b0;
    #1;
    exp_tbl = '0;
    exp_valid = 1'b0;
    n_checks++;
    if ({bus.busy, bus.sample_stb, bus.table_valid, bus.aborted} !== 4'b0 || bus.bit_idx !== 5'd0 || bus.wavetable_out !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: flags=%b idx=%0d table=%h, need all 0",
                         {bus.busy, bus.sample_stb, bus.table_valid, bus.aborted}, bus.bit_idx, bus.wavetable_out);
    end
    ab0 = n_abort;
    steps(3);
    rst_n = 1'b1;
    capture(32'hA5A5_0F0F);
    steps(3);
    exp_tbl = 32'hA5A5_0F0F;
    exp_valid = 1'b1;
    n_checks++;
    if (bus.wavetable_out !== exp_tbl || bus.table_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_capture: table=%h valid=%b busy=%b", bus.wavetable_out, bus.table_valid, bus.busy);
    end
    n_checks++;
    if (n_abort != ab0) begin n_fail++; $display("FAIL reset_no_abort: got %0d pulses, need 0", n_abort - ab0); end
    bus.record = 1'b0;
    steps(4);
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_hold_no_retrigger();
    test_abort();
    test_commit_hold();
    test_ack_clear();
    test_back_to_back();
    test_reset_mid_capture();
    n_checks++;
    if (n_stray != 0) begin n_fail++; $display("FAIL stray_strobes: got %0d, need 0", n_stray); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
